regfile_mp: RTL and testbench

- Parametrised multi-port register file; successor to the single-write, dual-read 32x32 register file used in the pipeline datapath.
- Adds the following over the previous block:
  - configurable data width, depth and read-port count
  - two write ports with defined priority
  - same-cycle write-to-read bypass
  - asynchronous reset of the array
  - a per-register busy scoreboard the decode stage uses for RAW hazard detection
  - a sticky write-collision flag
- Sits between the decode stage (reads, issue) and the writeback stage (writes).

---
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, optional write-to-read bypass,
// a per-register busy scoreboard for RAW hazard detection and a sticky write-collision flag.
module regfile_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we0,
   input  logic [ADDR_W-1:0]          waddr0,
   input  logic [DATA_W-1:0]          wdata0,
   input  logic                       we1,
   input  logic [ADDR_W-1:0]          waddr1,
   input  logic [DATA_W-1:0]          wdata1,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr,
   output logic [NUM_RD*DATA_W-1:0]   rdata,
   output logic [NUM_RD-1:0]          rbusy,
   input  logic                       issue_vld,
   input  logic [ADDR_W-1:0]          issue_addr,
   output logic                       wr_collide,
   input  logic                       clr_collide
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic              collide_q, collide_d;

   logic we0_ok, we1_ok, we0_eff, iss_ok, same_waddr;

   // Register 0 is hardwired to zero when ZERO_REG is set: writes and issues to it are dropped.
   function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
      return !((ZERO_REG != 0) && (a == '0));
   endfunction

   always_comb begin
      same_waddr = (waddr0 == waddr1);
      we0_ok     = we0 && addr_legal(waddr0);
      we1_ok     = we1 && addr_legal(waddr1);
      iss_ok     = issue_vld && addr_legal(issue_addr);
      // Port 1 wins a same-address collision; port 0 is dropped.
      we0_eff    = we0_ok && !(we1_ok && same_waddr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else begin
         if (we0_eff) mem_q[waddr0] <= wdata0;
         if (we1_ok)  mem_q[waddr1] <= wdata1;
      end
   end

   // Scoreboard: writes retire a producer, issue installs a newer one (issue applied last wins).
   always_comb begin
      busy_d = busy_q;
      if (we0_ok) busy_d[waddr0] = 1'b0;
      if (we1_ok) busy_d[waddr1] = 1'b0;
      if (iss_ok) busy_d[issue_addr] = 1'b1;
   end

   always_comb begin
      collide_d = collide_q;
      if (clr_collide) collide_d = 1'b0;
      if (we0_ok && we1_ok && same_waddr) collide_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= '0;
         collide_q <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         collide_q <= collide_d;
      end
   end

   assign wr_collide = collide_q;

   // Per-port combinational read with optional forwarding of this cycle's write data.
   for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              hit1, hit0, zero_rd;

      assign ra      = raddr[g*ADDR_W +: ADDR_W];
      assign zero_rd = (ZERO_REG != 0) && (ra == '0);
      assign hit1    = (BYPASS != 0) && we1_ok && (waddr1 == ra);
      assign hit0    = (BYPASS != 0) && we0_ok && (waddr0 == ra);

      assign rdata[g*DATA_W +: DATA_W] = zero_rd ? '0     :
                                         hit1    ? wdata1 :
                                         hit0    ? wdata0 :
                                                   mem_q[ra];
      assign rbusy[g] = !zero_rd && !hit1 && !hit0 && busy_q[ra];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing 32-bit/2-port instance and a non-bypassing 16-bit/4-port
// instance, checked against array-based reference models built from the read/write rules.
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        we0, we1, issue_vld, clr_collide;
   logic [4:0]  waddr0, waddr1, issue_addr;
   logic [31:0] wdata0, wdata1;
   logic [9:0]  raddr_a;
   logic [63:0] rdata_a;
   logic [1:0]  rbusy_a;
   logic        wr_collide_a;

   logic        b_we0, b_we1, b_issue_vld, b_clr;
   logic [4:0]  b_waddr0, b_waddr1, b_issue_addr;
   logic [15:0] b_wdata0, b_wdata1;
   logic [19:0] b_raddr;
   logic [63:0] b_rdata;
   logic [3:0]  b_rbusy;
   logic        b_collide;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
      .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
      .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
      .issue_vld(issue_vld), .issue_addr(issue_addr),
      .wr_collide(wr_collide_a), .clr_collide(clr_collide)
   );

   regfile_mp #(.DATA_W(16), .ADDR_W(5), .NUM_RD(4), .BYPASS(0), .ZERO_REG(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .we0(b_we0), .waddr0(b_waddr0), .wdata0(b_wdata0),
      .we1(b_we1), .waddr1(b_waddr1), .wdata1(b_wdata1),
      .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
      .issue_vld(b_issue_vld), .issue_addr(b_issue_addr),
      .wr_collide(b_collide), .clr_collide(b_clr)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] ma [32];
   bit          ba [32];
   bit          ca;
   logic [15:0] mb [32];
   bit          bb [32];
   bit          cb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         ma[i] = '0; ba[i] = 1'b0; mb[i] = '0; bb[i] = 1'b0;
      end
      ca = 1'b0; cb = 1'b0;
   endtask

   // Expected read for the bypassing instance: r0 is zero, port 1 forward, port 0 forward, array.
   function automatic logic [31:0] exp_rd_a(input int a);
      if (a == 0) return 32'h0;
      if (we1 && int'(waddr1) == a) return wdata1;
      if (we0 && int'(waddr0) == a) return wdata0;
      return ma[a];
   endfunction

   function automatic bit exp_busy_a(input int a);
      if (a == 0) return 1'b0;
      if ((we1 && int'(waddr1) == a) || (we0 && int'(waddr0) == a)) return 1'b0;
      return ba[a];
   endfunction

   task automatic check_a(input string tag);
      for (int p = 0; p < 2; p++) begin
         int a;
         a = int'(raddr_a[p*5 +: 5]);
         chk({tag, "_rd"}, rdata_a[p*32 +: 32], exp_rd_a(a));
         chk({tag, "_busy"}, 32'(rbusy_a[p]), 32'(exp_busy_a(a)));
      end
      chk({tag, "_col"}, 32'(wr_collide_a), 32'(ca));
   endtask

   // Non-bypassing instance: read data and busy come from stored state only.
   task automatic check_b(input string tag);
      for (int p = 0; p < 4; p++) begin
         int a;
         a = int'(b_raddr[p*5 +: 5]);
         chk({tag, "_rd"}, 32'(b_rdata[p*16 +: 16]), (a == 0) ? 32'h0 : 32'(mb[a]));
         chk({tag, "_busy"}, 32'(b_rbusy[p]), (a == 0) ? 32'h0 : 32'(bb[a]));
      end
      chk({tag, "_col"}, 32'(b_collide), 32'(cb));
   endtask

   task automatic edge_update();
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (we0 && waddr0 != 5'd0 && !(we1 && waddr1 == waddr0)) ma[waddr0] = wdata0;
      if (we1 && waddr1 != 5'd0) ma[waddr1] = wdata1;
      if (we0 && waddr0 != 5'd0) ba[waddr0] = 1'b0;
      if (we1 && waddr1 != 5'd0) ba[waddr1] = 1'b0;
      if (issue_vld && issue_addr != 5'd0) ba[issue_addr] = 1'b1;
      if (clr_collide) ca = 1'b0;
      if (we0 && we1 && waddr0 == waddr1 && waddr0 != 5'd0) ca = 1'b1;

      if (b_we0 && b_waddr0 != 5'd0 && !(b_we1 && b_waddr1 == b_waddr0)) mb[b_waddr0] = b_wdata0;
      if (b_we1 && b_waddr1 != 5'd0) mb[b_waddr1] = b_wdata1;
      if (b_we0 && b_waddr0 != 5'd0) bb[b_waddr0] = 1'b0;
      if (b_we1 && b_waddr1 != 5'd0) bb[b_waddr1] = 1'b0;
      if (b_issue_vld && b_issue_addr != 5'd0) bb[b_issue_addr] = 1'b1;
      if (b_clr) cb = 1'b0;
      if (b_we0 && b_we1 && b_waddr0 == b_waddr1 && b_waddr0 != 5'd0) cb = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      edge_update();
      #1;
   endtask

   task automatic idle();
      we0 = 1'b0; waddr0 = '0; wdata0 = '0;
      we1 = 1'b0; waddr1 = '0; wdata1 = '0;
      issue_vld = 1'b0; issue_addr = '0; clr_collide = 1'b0; raddr_a = '0;
      b_we0 = 1'b0; b_waddr0 = '0; b_wdata0 = '0;
      b_we1 = 1'b0; b_waddr1 = '0; b_wdata1 = '0;
      b_issue_vld = 1'b0; b_issue_addr = '0; b_clr = 1'b0; b_raddr = '0;
   endtask

   task automatic scan_zero(input string tag);
      for (int a = 0; a < 32; a += 2) begin
         raddr_a = {5'(a + 1), 5'(a)};
         #1;
         check_a(tag);
         chk({tag, "_z0"}, rdata_a[31:0], 32'h0);
         chk({tag, "_z1"}, rdata_a[63:32], 32'h0);
         chk({tag, "_nb"}, 32'(rbusy_a), 32'h0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      #2;
      check_a("rst");
      check_b("rst_b");
      #10 rst_n = 1'b1;
      tick();

      // 1: write then read back, and forward before the write edge
      idle(); we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr_a = {5'd0, 5'd5};
      #1; check_a("t1_pre"); chk("t1_bypass", rdata_a[31:0], 32'hDEADBEEF); tick();
      idle(); raddr_a = {5'd0, 5'd5};
      #1; check_a("t1_post"); chk("t1_array", rdata_a[31:0], 32'hDEADBEEF); tick();

      // 2: same-address collision, then sticky clear
      idle(); we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11; we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
      raddr_a = {5'd7, 5'd7};
      #1; check_a("t2_pre"); chk("t2_byp", rdata_a[31:0], 32'h22); tick();
      idle(); raddr_a = {5'd7, 5'd7}; clr_collide = 1'b1;
      #1; check_a("t2_set"); chk("t2_r7", rdata_a[31:0], 32'h22); chk("t2_col_set", 32'(wr_collide_a), 32'h1);
      tick();
      idle(); #1; check_a("t2_clr"); chk("t2_col_clr", 32'(wr_collide_a), 32'h0); tick();

      // 3: register 0 ignores writes and issues
      idle(); we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; issue_vld = 1'b1; issue_addr = 5'd0;
      #1; check_a("t3_pre"); chk("t3_rd", rdata_a[31:0], 32'h0); tick();
      idle(); #1; check_a("t3_post"); chk("t3_rd_post", rdata_a[31:0], 32'h0);
      chk("t3_busy", 32'(rbusy_a[0]), 32'h0); tick();

      // 4: scoreboard set, bypass clear, set-wins-over-clear
      idle(); issue_vld = 1'b1; issue_addr = 5'd3; #1; check_a("t4_iss"); tick();
      idle(); raddr_a = {5'd3, 5'd0}; #1; check_a("t4_b"); chk("t4_busy", 32'(rbusy_a[1]), 32'h1); tick();
      idle(); raddr_a = {5'd3, 5'd0}; we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h55;
      #1; check_a("t4_w"); chk("t4_fwd_busy", 32'(rbusy_a[1]), 32'h0); chk("t4_fwd", rdata_a[63:32], 32'h55);
      tick();
      idle(); raddr_a = {5'd3, 5'd0}; #1; check_a("t4_c"); chk("t4_cleared", 32'(rbusy_a[1]), 32'h0); tick();
      idle(); raddr_a = {5'd3, 5'd0}; issue_vld = 1'b1; issue_addr = 5'd3;
      we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h66; #1; check_a("t4_both"); tick();
      idle(); raddr_a = {5'd3, 5'd0};
      #1; check_a("t4_win"); chk("t4_setwins", 32'(rbusy_a[1]), 32'h1); chk("t4_r3", rdata_a[63:32], 32'h66);
      tick();

      // 5: fill, then asynchronous reset mid-cycle
      for (int r = 1; r < 32; r++) begin
         idle(); we0 = 1'b1; waddr0 = 5'(r); wdata0 = 32'(r); issue_vld = 1'b1; issue_addr = 5'(r);
         raddr_a = {5'(r), 5'(r)};
         #1; check_a("t5_fill"); tick();
      end
      idle(); raddr_a = {5'd31, 5'd30};
      #1; chk("t5_busy31", 32'(rbusy_a[1]), 32'h1); chk("t5_r30", rdata_a[31:0], 32'd30);
      #2 rst_n = 1'b0;
      model_reset();
      #1; chk("t5_immediate", rdata_a[31:0], 32'h0);
      scan_zero("t5_in");
      @(negedge clk) rst_n = 1'b1;
      tick();
      scan_zero("t5_out");
      tick();

      // 6: non-bypassing 4-port instance sees the old value until after the edge
      idle(); b_we0 = 1'b1; b_waddr0 = 5'd2; b_wdata0 = 16'hABCD; b_raddr = {4{5'd2}};
      #1; check_b("t6_pre");
      for (int p = 0; p < 4; p++) chk("t6_old", 32'(b_rdata[p*16 +: 16]), 32'h0);
      tick();
      idle(); b_raddr = {4{5'd2}};
      #1; check_b("t6_post");
      for (int p = 0; p < 4; p++) chk("t6_new", 32'(b_rdata[p*16 +: 16]), 32'h0000ABCD);
      tick();

      // Randomised traffic on a small address range to provoke collisions and hazards
      for (int n = 0; n < 400; n++) begin
         we0 = 1'($urandom_range(0, 1)); waddr0 = 5'($urandom_range(0, 7)); wdata0 = $urandom;
         we1 = 1'($urandom_range(0, 1)); waddr1 = 5'($urandom_range(0, 7)); wdata1 = $urandom;
         issue_vld = 1'($urandom_range(0, 1)); issue_addr = 5'($urandom_range(0, 7));
         clr_collide = ($urandom_range(0, 7) == 0);
         raddr_a = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         b_we0 = 1'($urandom_range(0, 1)); b_waddr0 = 5'($urandom_range(0, 7)); b_wdata0 = 16'($urandom);
         b_we1 = 1'($urandom_range(0, 1)); b_waddr1 = 5'($urandom_range(0, 7)); b_wdata1 = 16'($urandom);
         b_issue_vld = 1'($urandom_range(0, 1)); b_issue_addr = 5'($urandom_range(0, 7));
         b_clr = ($urandom_range(0, 7) == 0);
         for (int p = 0; p < 4; p++) b_raddr[p*5 +: 5] = 5'($urandom_range(0, 7));
         #1;
         check_a("rnd_a");
         check_b("rnd_b");
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
